// File: rtl/seq_calc_pkg.sv
// seq_calc_pkg: shared opcode and FSM state types for the sequential calculator.
package seq_calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    DIV_ITER = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Only a division by a non-zero divisor needs the iterative divider;
  // everything else (including divide-by-zero) resolves in one EXEC cycle.
  function automatic logic needs_iter(input op_e op, input logic divisor_nonzero);
    return (op == OP_DIV) && divisor_nonzero;
  endfunction

endpackage

// File: rtl/seq_div.sv
// seq_div: iterative restoring divider, one quotient bit per cycle, MSB first.
// start loads the operands; WIDTH iterations follow. done is asserted during
// the final iteration cycle, and quotient/remainder present that iteration's
// outcome so the parent can capture the answer on the same edge.
module seq_div
  import seq_calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] part_rem_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CW-1:0]    count_reg;
  logic             active_reg;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] quot_step;
  logic [WIDTH-1:0] rem_step;

  // One restoring step: shift in the next dividend bit, try the subtraction,
  // keep it only if it did not borrow.
  always_comb begin
    rem_shift = {part_rem_reg, quot_reg[WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor_reg};
    fits      = ~trial[WIDTH];
    quot_step = {quot_reg[WIDTH-2:0], fits};
    rem_step  = fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

  assign done      = active_reg && (count_reg == CW'(1));
  assign quotient  = quot_step;
  assign remainder = rem_step;

  // Operand load on start, then one step per cycle until the count runs out.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      quot_reg     <= '0;
      part_rem_reg <= '0;
      divisor_reg  <= '0;
      count_reg    <= '0;
      active_reg   <= 1'b0;
    end else if (start) begin
      quot_reg     <= dividend;
      part_rem_reg <= '0;
      divisor_reg  <= divisor;
      count_reg    <= CW'(WIDTH);
      active_reg   <= 1'b1;
    end else if (active_reg) begin
      quot_reg     <= quot_step;
      part_rem_reg <= rem_step;
      count_reg    <= count_reg - CW'(1);
      if (count_reg == CW'(1)) begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_calc.sv
// seq_calc: sequential ADD/SUB/MUL/DIV calculator with start/busy/done handshake.
// Optional feature macro SEQ_CALC_REM_EN adds the registered DIV remainder
// output port rem.
module seq_calc
  import seq_calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             dbz
`ifdef SEQ_CALC_REM_EN
  ,
  output logic [WIDTH-1:0] rem
`endif
);

  state_e state_reg, state_next;

  op_e              op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH-1:0] result_reg;
  logic             ovf_reg;
  logic             dbz_reg;

  logic             accept;
  logic             iter_needed;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     difference;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_ovf;
  logic               alu_dbz;

  assign accept      = (state_reg == IDLE) && start;
  assign iter_needed = needs_iter(op_reg, |b_reg);
  assign div_start   = (state_reg == EXEC) && iter_needed;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = EXEC;
      EXEC:     state_next = iter_needed ? DIV_ITER : DONE;
      DIV_ITER: if (div_done) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Capture the operation at the accept edge so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_reg <= OP_ADD;
      a_reg  <= '0;
      b_reg  <= '0;
    end else if (accept) begin
      op_reg <= op_e'(op);
      a_reg  <= a;
      b_reg  <= b;
    end
  end

  // Single-cycle ADD/SUB/MUL and the divide-by-zero shortcut, all modulo 2^WIDTH.
  always_comb begin
    sum        = {1'b0, a_reg} + {1'b0, b_reg};
    difference = {1'b0, a_reg} - {1'b0, b_reg};
    product    = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
    alu_result = '0;
    alu_ovf    = 1'b0;
    alu_dbz    = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_result = sum[WIDTH-1:0];
        alu_ovf    = sum[WIDTH];
      end
      OP_SUB: begin
        alu_result = difference[WIDTH-1:0];
        alu_ovf    = difference[WIDTH];
      end
      OP_MUL: begin
        alu_result = product[WIDTH-1:0];
        alu_ovf    = |product[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        alu_result = '1;
        alu_dbz    = 1'b1;
      end
      default: begin
        alu_result = '0;
      end
    endcase
  end

`ifdef SEQ_CALC_REM_EN
  logic [WIDTH-1:0] div_remainder;
`else
  logic [WIDTH-1:0] div_remainder_unused;
`endif

  seq_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .dividend  (a_reg),
    .divisor   (b_reg),
    .done      (div_done),
    .quotient  (div_quotient),
`ifdef SEQ_CALC_REM_EN
    .remainder (div_remainder)
`else
    .remainder (div_remainder_unused)
`endif
  );

  // Result registers: loaded from the inline ALU in EXEC or from the divider's final step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      dbz_reg    <= 1'b0;
    end else if ((state_reg == EXEC) && !iter_needed) begin
      result_reg <= alu_result;
      ovf_reg    <= alu_ovf;
      dbz_reg    <= alu_dbz;
    end else if ((state_reg == DIV_ITER) && div_done) begin
      result_reg <= div_quotient;
      ovf_reg    <= 1'b0;
      dbz_reg    <= 1'b0;
    end
  end

`ifdef SEQ_CALC_REM_EN
  logic [WIDTH-1:0] rem_reg;

  // Remainder register, updated alongside result; zero for non-DIV operations.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_reg <= '0;
    end else if ((state_reg == EXEC) && !iter_needed) begin
      rem_reg <= (op_reg == OP_DIV) ? a_reg : '0;
    end else if ((state_reg == DIV_ITER) && div_done) begin
      rem_reg <= div_remainder;
    end
  end

  assign rem = rem_reg;
`endif

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign ovf    = ovf_reg;
  assign dbz    = dbz_reg;

endmodule

// File: tb/tb_seq_calc.sv
// tb_seq_calc: self-checking bench for seq_calc (WIDTH=8): directed vector
// table, reset/back-to-back sequences, then randomized ops vs. a reference model.
module tb_seq_calc;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;
  logic         dbz;
`ifdef SEQ_CALC_REM_EN
  logic [W-1:0] rem;
`endif

  int checks = 0;
  int errors = 0;

  seq_calc #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .dbz    (dbz)
`ifdef SEQ_CALC_REM_EN
    ,
    .rem    (rem)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int         a;
    int         b;
    int         res;
    int         ovf;
    int         dbz;
    int         rem;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules.
  function automatic void model(input int o, input int x, input int y,
                                output int r, output int ov, output int dz,
                                output int rm, output int lat);
    r = 0; ov = 0; dz = 0; rm = 0; lat = 1;
    case (o)
      0: begin r = (x + y) % 256; ov = (x + y > 255) ? 1 : 0; end
      1: begin r = (x - y + 256) % 256; ov = (x < y) ? 1 : 0; end
      2: begin r = (x * y) % 256; ov = (x * y > 255) ? 1 : 0; end
      default: begin
        if (y == 0) begin r = 255; dz = 1; rm = x; end
        else begin r = x / y; rm = x % y; lat = W + 1; end
      end
    endcase
  endfunction

  // Present a request; call at a negedge while the DUT is idle.
  task automatic issue(input logic [1:0] o, input int x, input int y);
    start = 1'b1;
    op    = o;
    a     = x[W-1:0];
    b     = y[W-1:0];
  endtask

  // Let the accept edge happen, scramble inputs, then check timing and outputs.
  task automatic complete(input string name, input int er, input int eo,
                          input int ed, input int erem, input int elat);
    int  lat;
    int  busy_n;
    bit  got;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    op     = 2'($urandom);
    lat    = 0;
    busy_n = 0;
    got    = 1'b0;
    @(negedge clk);
    if (busy) busy_n++;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy) busy_n++;
      if (done) got = 1'b1;
    end
    check({name, " done_seen"}, int'(got), 1);
    check({name, " latency"}, lat, elat);
    check({name, " busy_cycles"}, busy_n, elat + 1);
    check({name, " result"}, int'(result), er);
    check({name, " ovf"}, int'(ovf), eo);
    check({name, " dbz"}, int'(dbz), ed);
`ifdef SEQ_CALC_REM_EN
    check({name, " rem"}, int'(rem), erem);
`endif
    $display("txn %s result=%0d ovf=%0d dbz=%0d lat=%0d exp_result=%0d exp_rem=%0d",
             name, result, ovf, dbz, lat, er, erem);
    @(posedge clk);
    @(negedge clk);
    check({name, " done_pulse_end"}, int'(done), 0);
    check({name, " busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int r, ov, dz, rm, lat;
    int x, y, o;
    int j;

    vecs[0] = '{2'd0, 200, 100,  44, 1, 0,   0, 1};
    vecs[1] = '{2'd1,   5,   9, 252, 1, 0,   0, 1};
    vecs[2] = '{2'd2,  20,  13,   4, 1, 0,   0, 1};
    vecs[3] = '{2'd3, 200,   7,  28, 0, 0,   4, 9};
    vecs[4] = '{2'd3,   9,   0, 255, 0, 1,   9, 1};
    vecs[5] = '{2'd0,   1,   2,   3, 0, 0,   0, 1};
    vecs[6] = '{2'd3, 255,   1, 255, 0, 0,   0, 9};
    vecs[7] = '{2'd2,  15,  17, 255, 0, 0,   0, 1};
    vecs[8] = '{2'd1,   9,   5,   4, 0, 0,   0, 1};
    vecs[9] = '{2'd3,   7, 200,   0, 0, 0,   7, 9};

    resetn = 1'b0;
    start  = 1'b0;
    op     = 2'd0;
    a      = '0;
    b      = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset ovf", int'(ovf), 0);
    check("reset dbz", int'(dbz), 0);
`ifdef SEQ_CALC_REM_EN
    check("reset rem", int'(rem), 0);
`endif
    resetn = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      complete($sformatf("vec%0d", i), vecs[i].res, vecs[i].ovf, vecs[i].dbz,
               vecs[i].rem, vecs[i].lat);
    end

    // Reset in the middle of a division, then immediate accept after release.
    @(negedge clk);
    issue(2'd0, 200, 100);
    complete("pre_reset_add", 44, 1, 0, 0, 1);
    @(negedge clk);
    issue(2'd3, 255, 1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset result", int'(result), 0);
    check("midreset ovf", int'(ovf), 0);
    check("midreset dbz", int'(dbz), 0);
`ifdef SEQ_CALC_REM_EN
    check("midreset rem", int'(rem), 0);
`endif
    resetn = 1'b1;
    issue(2'd0, 1, 1);
    complete("post_reset_add", 2, 0, 0, 0, 1);

    // start held high: one accept every 3 cycles, done one cycle after each.
    @(negedge clk);
    issue(2'd0, 10, 3);
    j = 0;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk);
      #1;
      if (t % 3 == 0) begin
        a = W'(10 + 20 * (t / 3 + 1));
        b = W'(3 + (t / 3 + 1));
      end
      @(negedge clk);
      check($sformatf("b2b done t=%0d", t), int'(done), (t % 3 == 1) ? 1 : 0);
      if (t % 3 == 1) begin
        j = t / 3;
        check($sformatf("b2b result op%0d", j), int'(result), (10 + 20 * j + 3 + j) % 256);
        $display("txn b2b op%0d result=%0d", j, result);
      end
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b no extra accept", int'(busy), 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      o = int'($urandom_range(0, 3));
      x = int'($urandom_range(0, 255));
      y = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
      model(o, x, y, r, ov, dz, rm, lat);
      @(negedge clk);
      issue(o[1:0], x, y);
      complete($sformatf("rand%0d op=%0d a=%0d b=%0d", i, o, x, y), r, ov, dz, rm, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
